// File: rtl/button_event_decoder_pkg.sv
// Shared definitions for the button event decoder: FSM state encoding,
// 50 MHz default timing constants and a parameter range helper.
package button_event_defs;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_CNT_W          = 25;
    localparam int unsigned DEFAULT_LONG_PERIODS   = 25_000_000;
    localparam int unsigned DEFAULT_REPEAT_PERIODS = 5_000_000;

    // True when lo <= p <= 2**w - 1.
    function automatic bit period_ok(input longint unsigned p,
                                     input longint unsigned lo,
                                     input int unsigned w);
        return (p >= lo) && (p < (64'd1 << w));
    endfunction

endpackage

// File: rtl/button_event_decoder_if.sv
// Level input and event pulse outputs of the button event decoder.
interface button_event_decoder_if;

    logic level;
    logic press;
    logic release_pulse;
    logic long_press;
    logic repeat_pulse;
    logic held;

    modport master (
        input  level,
        output press,
        output release_pulse,
        output long_press,
        output repeat_pulse,
        output held
    );

    modport slave (
        output level,
        input  press,
        input  release_pulse,
        input  long_press,
        input  repeat_pulse,
        input  held
    );

endinterface

// File: rtl/button_event_decoder_sync_2ff.sv
// Two-flop synchronizer, 1 bit, asynchronous active-low reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into one-cycle press/release/long-press/
// auto-repeat pulses. Auto-repeat is built only with BUTTON_EVENT_REPEAT_EN.
module button_event_decoder
    import button_event_defs::*;
#(
    parameter int unsigned CNT_W          = DEFAULT_CNT_W,
    parameter int unsigned LONG_PERIODS   = DEFAULT_LONG_PERIODS,
    parameter int unsigned REPEAT_PERIODS = DEFAULT_REPEAT_PERIODS
) (
    input logic                    clock,
    input logic                    reset_n,
    button_event_decoder_if.master bus
);

    if (!period_ok(LONG_PERIODS, 2, CNT_W)) begin : g_bad_long
        $error("LONG_PERIODS outside 2 .. 2**CNT_W-1");
    end
    if (!period_ok(REPEAT_PERIODS, 1, CNT_W)) begin : g_bad_repeat
        $error("REPEAT_PERIODS outside 1 .. 2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_PERIODS - 1);

    logic lvl_s;

    sync_2ff u_sync (
        .clk   (clock),
        .rst_n (reset_n),
        .d     (bus.level),
        .q     (lvl_s)
    );

    state_e           state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             press_d, press_q;
    logic             release_d, release_q;
    logic             long_d, long_q;
    logic             held_d, held_q;
`ifdef BUTTON_EVENT_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_PERIODS - 1);
    logic             repeat_d, repeat_q;
`endif

    // Release is tested first in every held state so it wins over a
    // coincident long/repeat terminal count.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
        repeat_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (lvl_s) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            PRESSED: begin
                if (!lvl_s) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else if (cnt_q == LONG_TC) begin
                    state_d = LONG;
                    long_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LONG: begin
                if (!lvl_s) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end
`ifdef BUTTON_EVENT_REPEAT_EN
                else if (cnt_q == REPEAT_TC) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`else
                else begin
                    cnt_d = '0;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        held_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
            repeat_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            held_q    <= held_d;
`ifdef BUTTON_EVENT_REPEAT_EN
            repeat_q  <= repeat_d;
`endif
        end
    end

    assign bus.press         = press_q;
    assign bus.release_pulse = release_q;
    assign bus.long_press    = long_q;
    assign bus.held          = held_q;
`ifdef BUTTON_EVENT_REPEAT_EN
    assign bus.repeat_pulse  = repeat_q;
`else
    assign bus.repeat_pulse  = 1'b0;
`endif

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Consumes the debounced button level produced by the board's button debouncer and turns it into single-cycle UI events: press, release, long-press and auto-repeat. It sits between the debouncer and the scope control logic, such as timebase and trigger-level stepping. Downstream logic counts pulses and does not interpret raw levels. All event outputs are registered, one-cycle pulses in the `clock` domain.

## Interface
- `CNT_W`, 25: hold-counter width in bits.
- `LONG_PERIODS`, 25000000: cycles from press to long-press (0.5 s at 50 MHz). Valid range is 2 to 2^CNT_W-1.
- `REPEAT_PERIODS`, 5000000: cycles between auto-repeat pulses (100 ms). Valid range is 1 to 2^CNT_W-1.
- `clock`  in  1  system clock, 50 MHz.
- `reset_n`  in  1  asynchronous, active-low reset.
- `level`  in  1  debounced button level, 1 = pressed. May be asynchronous to `clock`.
- `press`  out  1  one-cycle pulse on press.
- `release`  out  1  one-cycle pulse on release.
- `long_press`  out  1  one-cycle pulse when hold time reaches `LONG_PERIODS`.
- `repeat`  out  1  one-cycle auto-repeat pulse.
- `held`  out  1  high while the FSM is not in IDLE.

## Operation
- `level` passes through a 2-flop synchronizer; the result is `lvl_s`. Both flops reset to 0.
- FSM states are IDLE, PRESSED and LONG. The hold counter `cnt` is `CNT_W` bits wide and unsigned.
- **IDLE**
  - On `lvl_s`=1: go to PRESSED, assert `press`, set `cnt`=0.
- **PRESSED**
  - On `lvl_s`=0: go to IDLE and assert `release`.
  - Else, if `cnt`==LONG_PERIODS-1: go to LONG, assert `long_press`, set `cnt`=0.
  - Otherwise: increment `cnt`.
- **LONG**
  - On `lvl_s`=0: go to IDLE and assert `release`.
  - Else, if `cnt`==REPEAT_PERIODS-1: assert `repeat` and set `cnt`=0.
  - Otherwise: increment `cnt`.
- Release has priority. If release and the long or repeat terminal count occur in the same cycle, only `release` fires and the FSM goes to IDLE.
- At most one event output is high in any cycle.
- `cnt` never wraps. It is always cleared at a terminal count or on a state change.
- `held` is 1 in PRESSED and LONG.

## Timing
- Reset values: `press`, `release`, `long_press`, `repeat` and `held` are all 0; state is IDLE; `cnt`=0; sync flops are 0.
- Press latency: `level` is first sampled high at edge N. `press` and `held` go high after edge N+2, and `press` lasts exactly one cycle.
- Release latency: also 3 edges from `level` being sampled low.
- `long_press` fires exactly `LONG_PERIODS` cycles after `press`.
- The first `repeat` fires `REPEAT_PERIODS` cycles after `long_press`. Subsequent repeats follow every `REPEAT_PERIODS` cycles.
- Reset mid-operation: all outputs drop immediately. If `level` is still high after `reset_n` deasserts, a fresh `press` is reported 3 edges later.
- A `level` pulse of 1 cycle is still reported as a `press` followed by a `release` 1 cycle apart. Glitch rejection is the debouncer's responsibility.

## Configuration
- The macro is `BUTTON_EVENT_REPEAT_EN`.
- **Defined:** LONG behaves as described under Operation.
- **Undefined:**
  - LONG holds `cnt` at 0 and only waits for release.
  - `repeat` is tied to 0.
  - `REPEAT_PERIODS` is ignored.
- Press, release and long-press behaviour is identical in both builds.

## Structure
- The shared package/header `button_event_defs` holds:
  - the state encodings: IDLE=2'd0, PRESSED=2'd1, LONG=2'd2;
  - the default `LONG_PERIODS` and `REPEAT_PERIODS` constants for 50 MHz.
- The sub-module `sync_2ff` (1-bit, async active-low reset to 0) is also reused for other panel inputs.

## Test plan
Tests use `LONG_PERIODS`=8 and `REPEAT_PERIODS`=3.
1. **Reset values:** with `reset_n`=0 and `level`=1, all outputs are 0. After `reset_n` rises, `press` pulses 3 edges later and `held` becomes 1.
2. **Short press:** hold `level` high for 5 cycles. Expect `press`, then `release` 5 cycles later, with no `long_press` or `repeat`.
3. **Long hold with repeat enabled:** hold `level` for 20 cycles. Expect:
   - `long_press` 8 cycles after `press`;
   - `repeat` at +3, +6 and +9 after `long_press`;
   - `release` 3 edges after `level` falls.
4. **Repeat disabled:** rebuild without `BUTTON_EVENT_REPEAT_EN` and repeat scenario 3. Expect `long_press` only, `repeat` always 0, and `release` as before.
5. **Priority collision:** time `level` so `lvl_s` falls exactly in the cycle where `cnt`==7 in PRESSED. Expect only `release`, no `long_press`, and the FSM in IDLE.
6. **Reset mid-hold:** pulse `reset_n` low in LONG. Outputs clear asynchronously. With `level` still high, expect a new `press` 3 edges after reset release, and `long_press` 8 cycles after that.
